// File: rtl/mux_4_rr_arbiter.sv
// rtl/mux_4_rr_arbiter.sv - round-robin arbiter/sequencer for a 4-to-1 mux; MUX_ARB_TIMEOUT_EN enables hold-limit pre-emption
module mux_4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] S,
    output logic       EN,
    output logic       BUSY
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] s_q;
    logic [1:0] last_q;
    logic       en_q;

    logic [3:0] cand_d;
    logic [1:0] win_d;
    logic       owner_req_d;
    logic       others_d;
    logic       timeout_d;

    if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << CW) <= MAX_HOLD) begin : g_bad_params
        $error("mux_4_rr_arbiter: MAX_HOLD must be 2..15 and below 2**CW");
    end

    // First set bit scanning LAST+1, LAST+2, LAST+3, LAST; later offsets are overwritten by earlier ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // The owner is masked out so a pre-empted owner cannot immediately win itself back.
    always_comb begin
        cand_d      = REQ & ~gnt_q;
        win_d       = rr_pick(cand_d, last_q);
        owner_req_d = |(REQ & gnt_q);
        others_d    = |cand_d;
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q;
    assign timeout_d = owner_req_d && others_d && (cnt_q >= CW'(MAX_HOLD - 1));
`else
    assign timeout_d = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
            en_q    <= 1'b0;
            last_q  <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|REQ) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= 4'b0001 << win_d;
                        s_q     <= win_d;
                        en_q    <= 1'b1;
                        last_q  <= win_d;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (owner_req_d && !timeout_d) begin
`ifdef MUX_ARB_TIMEOUT_EN
                        if (cnt_q != {CW{1'b1}}) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end else if (others_d) begin
                        gnt_q   <= 4'b0001 << win_d;
                        s_q     <= win_d;
                        last_q  <= win_d;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        en_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign GNT  = gnt_q;
    assign S    = s_q;
    assign EN   = en_q;
    assign BUSY = (|REQ) || en_q;

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// tb/tb_mux_4_rr_arbiter.sv - scoreboard bench for mux_4_rr_arbiter against a behavioural model
module tb_mux_4_rr_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CW       = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] S;
    logic       EN;
    logic       BUSY;

    mux_4_rr_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .CW      (CW)
    ) dut (
        .CLK (CLK),
        .RST_N(RST_N),
        .REQ (REQ),
        .GNT (GNT),
        .S   (S),
        .EN  (EN),
        .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Model: who owns the mux, who won last, and how many cycles the owner has held it.
    int m_active;
    int m_owner;
    int m_last;
    int m_s;
    int m_held;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_owner  = 0;
        m_last   = 3;
        m_s      = 0;
        m_held   = 0;
    endtask

    task automatic grant_to(input int w);
        m_active = 1;
        m_owner  = w;
        m_s      = w;
        m_last   = w;
        m_held   = 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        bit keep;
        if (m_active == 0) begin
            if (r != 4'b0000) grant_to(pick(r, m_last));
        end else begin
            others = r & ~(4'b0001 << m_owner);
            keep = r[m_owner] && !(TIMEOUT_EN && m_held >= MAX_HOLD && others != 4'b0000);
            if (keep) m_held++;
            else if (others != 4'b0000) grant_to(pick(others, m_last));
            else m_active = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        model_step(REQ);
    endtask

    task automatic drive(input logic [3:0] r);
        logic [3:0] g;
        REQ = r;
        g = (m_active != 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_q.push_back({g, 2'(m_s), (m_active != 0), ((r != 4'b0000) || (m_active != 0))});
    endtask

    always @(negedge CLK) begin : monitor
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard{GNT,S,EN,BUSY}", {GNT, S, EN, BUSY}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r;
        int held0;
        bit run;

        RST_N = 1'b0;
        REQ   = 4'b0000;
        model_reset();
        #12;
        check("reset_state", {GNT, S, EN, BUSY}, 8'b0000_00_0_0);
        RST_N = 1'b1;

        repeat (5) begin
            tick();
            drive(4'b0000);
        end

        // All requesting; each owner drops out for one cycle after holding two.
        for (int c = 0; c < 14; c++) begin
            tick();
            r = 4'b1111;
            if (m_active != 0 && m_held >= 2) r[m_owner] = 1'b0;
            drive(r);
        end

        tick(); drive(4'b0000);
        tick(); drive(4'b0000);
        for (int c = 0; c < 3; c++) begin
            tick();
            drive(4'b0100);
        end
        tick(); drive(4'b0000);
        tick(); drive(4'b0000);
        tick(); drive(4'b1100);
        tick(); drive(4'b1100);
        tick(); drive(4'b0000);

        // Asynchronous reset mid-grant with owner 1, then a 1010 request after release.
        for (int c = 0; c < 3; c++) begin
            tick();
            drive(4'b0010);
        end
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        REQ   = 4'b1010;
        #1;
        check("async_reset{GNT,S,EN}", {1'b0, GNT, S, EN}, 8'b0);
        model_reset();
        #2;
        RST_N = 1'b1;
        tick(); drive(4'b1010);
        tick(); drive(4'b0000);
        tick(); drive(4'b0000);

        // Owner 0 held against a competing requester 2.
        tick(); drive(4'b0001);
        held0 = 0;
        run   = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (run && GNT == 4'b0001 && S == 2'd0) held0++;
            else run = 1'b0;
            drive(4'b0101);
        end
        check("hold_len_owner0", 8'(held0), TIMEOUT_EN ? 8'd8 : 8'd50);
        tick(); drive(4'b0000);
        tick(); drive(4'b0000);

        // Lone requester for a long stretch, then a competitor appears.
        for (int c = 0; c < 40; c++) begin
            tick();
            drive(4'b0001);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            drive(4'b0011);
        end
        tick(); drive(4'b0000);

        for (int c = 0; c < 1500; c++) begin
            tick();
            r = REQ;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
            end
            if ($urandom_range(0, 31) == 0) r = 4'b0000;
            drive(r);
        end

        tick(); drive(4'b0000);
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
